// File: rtl/mem_port_arbiter64_if.sv
// mem_port_arbiter64_if
//   Bundles the fetch port, the data port and the shared memory port that
//   mem_port_arbiter64 arbitrates between.
//   slave  : the arbiter's view (requests in, responses and mem_* out)
//   master : the environment's view (core front-ends plus memory)
//
//   fetch : i_read, i_address, flush -> i_valid, i_data, i_mem_hazard
//   data  : d_read, d_write, d_address, d_wdata, d_log2_bytes
//           -> d_valid, d_rdata, d_mem_issue_hazard, d_mem_recv_hazard
//   mem   : mem_read, mem_write, mem_address, mem_wdata, mem_log2_bytes
//           <- mem_ready, mem_valid, mem_rdata
interface mem_port_arbiter64_if #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDRESS_BITS = 32
);
   logic                    i_read;
   logic [ADDRESS_BITS-1:0] i_address;
   logic                    flush;
   logic                    i_valid;
   logic [DATA_WIDTH-1:0]   i_data;

   logic                    d_read;
   logic                    d_write;
   logic [ADDRESS_BITS-1:0] d_address;
   logic [DATA_WIDTH-1:0]   d_wdata;
   logic [2:0]              d_log2_bytes;
   logic                    d_valid;
   logic [DATA_WIDTH-1:0]   d_rdata;

   logic                    mem_read;
   logic                    mem_write;
   logic [ADDRESS_BITS-1:0] mem_address;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [2:0]              mem_log2_bytes;
   logic                    mem_ready;
   logic                    mem_valid;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   logic                    i_mem_hazard;
   logic                    d_mem_issue_hazard;
   logic                    d_mem_recv_hazard;

   modport slave (
      input  i_read, i_address, flush,
      output i_valid, i_data,
      input  d_read, d_write, d_address, d_wdata, d_log2_bytes,
      output d_valid, d_rdata,
      output mem_read, mem_write, mem_address, mem_wdata, mem_log2_bytes,
      input  mem_ready, mem_valid, mem_rdata,
      output i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard
   );

   modport master (
      output i_read, i_address, flush,
      input  i_valid, i_data,
      output d_read, d_write, d_address, d_wdata, d_log2_bytes,
      input  d_valid, d_rdata,
      input  mem_read, mem_write, mem_address, mem_wdata, mem_log2_bytes,
      output mem_ready, mem_valid, mem_rdata,
      input  i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard
   );
endinterface

// File: rtl/mem_port_arbiter64.sv
// mem_port_arbiter64
//   Shares one single-outstanding memory port between an instruction-fetch
//   requester and a load/store requester. Data normally wins; a waiting fetch
//   is forced through after STARVE_LIMIT consecutive data grants. A flush
//   discards an in-flight fetch, whose late response is then drained silently.
//
//   Ports
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_port_arbiter64_if.slave (fetch, data and memory signals)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction outstanding, arbitrating and issuing
//   WAIT_I  | fetch accepted by memory, waiting for its response
//   WAIT_D  | load/store accepted by memory, waiting for its response
//   DRAIN_I | flushed fetch still in flight, its response is discarded
module mem_port_arbiter64 #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDRESS_BITS = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic                  clock,
   input logic                  reset,
   mem_port_arbiter64_if.slave  bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT_I  = 2'd1;
   localparam logic [1:0] S_WAIT_D  = 2'd2;
   localparam logic [1:0] S_DRAIN_I = 2'd3;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] starve_cnt;
   logic [3:0] starve_cnt_nxt;

   logic in_idle;
   logic data_req;
   logic fetch_first;
   logic grant_i;
   logic grant_d;
   logic issue_i;
   logic issue_d;
   logic accept_i;
   logic accept_d;
   logic resp_i;
   logic resp_d;

   logic                    mem_read_c;
   logic                    mem_write_c;
   logic [ADDRESS_BITS-1:0] mem_address_c;
   logic [DATA_WIDTH-1:0]   mem_wdata_c;
   logic [2:0]              mem_log2_bytes_c;
   logic [DATA_WIDTH-1:0]   i_data_c;
   logic [DATA_WIDTH-1:0]   d_rdata_c;

   // Arbitration. fetch_first is the IDLE priority decision; a flush only
   // suppresses the fetch issue, it does not hand the slot to data.
   always_comb begin
      in_idle     = (state == S_IDLE);
      data_req    = bus.d_read | bus.d_write;
      fetch_first = bus.i_read & ((starve_cnt == STARVE_MAX) | ~data_req);
      grant_i     = in_idle & fetch_first;
      grant_d     = in_idle & data_req & ~fetch_first;
      // Nothing reaches the memory port while reset is held.
      issue_i     = grant_i & ~bus.flush & reset;
      issue_d     = grant_d & reset;
      accept_i    = issue_i & bus.mem_ready;
      accept_d    = issue_d & bus.mem_ready;
   end

   always_comb begin
      mem_read_c       = 1'b0;
      mem_write_c      = 1'b0;
      mem_address_c    = '0;
      mem_wdata_c      = '0;
      mem_log2_bytes_c = 3'd0;
      if (issue_i) begin
         mem_read_c       = 1'b1;
         mem_address_c    = bus.i_address;
         mem_log2_bytes_c = 3'd3;
      end else if (issue_d) begin
         mem_read_c       = bus.d_read;
         mem_write_c      = bus.d_write;
         mem_address_c    = bus.d_address;
         mem_wdata_c      = bus.d_write ? bus.d_wdata : '0;
         mem_log2_bytes_c = bus.d_log2_bytes;
      end
   end

   // Responses only count in the wait states, so stray mem_valid in IDLE
   // (including a reply to a transaction cut short by reset) is ignored.
   always_comb begin
      resp_i    = (state == S_WAIT_I) & bus.mem_valid & ~bus.flush;
      resp_d    = (state == S_WAIT_D) & bus.mem_valid;
      i_data_c  = resp_i ? bus.mem_rdata : '0;
      d_rdata_c = resp_d ? bus.mem_rdata : '0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept_d) begin
               state_nxt = S_WAIT_D;
            end else if (accept_i) begin
               state_nxt = S_WAIT_I;
            end
         end
         S_WAIT_I: begin
            // A flush together with the response simply drops the data.
            if (bus.mem_valid) begin
               state_nxt = S_IDLE;
            end else if (bus.flush) begin
               state_nxt = S_DRAIN_I;
            end
         end
         S_WAIT_D: begin
            if (bus.mem_valid) begin
               state_nxt = S_IDLE;
            end
         end
         S_DRAIN_I: begin
            if (bus.mem_valid) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counts data grants that overtook a waiting fetch; saturating so the
   // forced fetch grant stays armed until the fetch is actually accepted.
   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (accept_d) begin
         if (bus.i_read) begin
            starve_cnt_nxt = (starve_cnt >= STARVE_MAX) ? STARVE_MAX
                                                        : starve_cnt + 4'd1;
         end else begin
            starve_cnt_nxt = 4'd0;
         end
      end else if (accept_i) begin
         starve_cnt_nxt = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   assign bus.mem_read       = mem_read_c;
   assign bus.mem_write      = mem_write_c;
   assign bus.mem_address    = mem_address_c;
   assign bus.mem_wdata      = mem_wdata_c;
   assign bus.mem_log2_bytes = mem_log2_bytes_c;

   assign bus.i_valid = resp_i;
   assign bus.i_data  = i_data_c;
   assign bus.d_valid = resp_d;
   assign bus.d_rdata = d_rdata_c;

   assign bus.i_mem_hazard       = bus.i_read & ~resp_i;
   assign bus.d_mem_issue_hazard = data_req & ~(grant_d & bus.mem_ready);
   assign bus.d_mem_recv_hazard  = (state == S_WAIT_D) & ~bus.mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter64.sv
module tb_mem_port_arbiter64;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int SL = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;

   mem_port_arbiter64_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) bus ();

   mem_port_arbiter64 #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .STARVE_LIMIT(SL)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Transaction-level reference: a list of in-flight transactions (at most
   // one), each remembering whether it is a fetch and whether a flush
   // orphaned it, plus a count of data grants that overtook a waiting fetch.
   typedef struct {
      bit is_fetch;
      bit dropped;
   } txn_t;

   txn_t pend[$];
   int   starve;
   int   n_checks;
   int   n_errors;

   logic          e_mrd, e_mwr, e_iv, e_dv, e_ihz, e_dihz, e_drhz;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_id, e_dr;
   logic [2:0]    e_log2;
   bit            m_issue_fetch;
   bit            acc_i, acc_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_eval();
      bit data_req;
      bit fetch_first;
      bit data_granted;
      if (!reset) begin
         pend.delete();
         starve = 0;
      end
      data_req     = bus.d_read | bus.d_write;
      fetch_first  = bus.i_read && (starve == SL || !data_req);
      data_granted = (pend.size() == 0) && data_req && !fetch_first;
      e_mrd = 1'b0; e_mwr = 1'b0; e_addr = '0; e_wdata = '0; e_log2 = 3'd0;
      e_iv  = 1'b0; e_id  = '0;   e_dv   = 1'b0; e_dr = '0;
      m_issue_fetch = 1'b0;
      if (reset && pend.size() == 0) begin
         if (fetch_first) begin
            if (!bus.flush) begin
               e_mrd = 1'b1; e_addr = bus.i_address; e_log2 = 3'd3;
               m_issue_fetch = 1'b1;
            end
         end else if (data_req) begin
            e_mrd   = bus.d_read;
            e_mwr   = bus.d_write;
            e_addr  = bus.d_address;
            e_wdata = bus.d_write ? bus.d_wdata : '0;
            e_log2  = bus.d_log2_bytes;
         end
      end
      if (pend.size() != 0 && bus.mem_valid) begin
         if (pend[0].is_fetch) begin
            if (!pend[0].dropped && !bus.flush) begin
               e_iv = 1'b1; e_id = bus.mem_rdata;
            end
         end else begin
            e_dv = 1'b1; e_dr = bus.mem_rdata;
         end
      end
      e_ihz  = bus.i_read & ~e_iv;
      e_dihz = data_req & ~(data_granted & bus.mem_ready);
      e_drhz = (pend.size() != 0) && !pend[0].is_fetch && !bus.mem_valid;
   endtask

   task automatic model_update();
      txn_t t;
      acc_i = 1'b0;
      acc_d = 1'b0;
      if (!reset) return;
      if (pend.size() == 0) begin
         if ((e_mrd | e_mwr) && bus.mem_ready) begin
            t.is_fetch = m_issue_fetch;
            t.dropped  = 1'b0;
            pend.push_back(t);
            if (m_issue_fetch) begin
               acc_i  = 1'b1;
               starve = 0;
            end else begin
               acc_d  = 1'b1;
               starve = bus.i_read ? ((starve < SL) ? starve + 1 : SL) : 0;
            end
         end
      end else if (bus.mem_valid) begin
         void'(pend.pop_front());
      end else if (pend[0].is_fetch && bus.flush) begin
         t = pend[0];
         t.dropped = 1'b1;
         pend[0] = t;
      end
   endtask

   task automatic check_all();
      chk("mem_read",    64'(bus.mem_read),           64'(e_mrd));
      chk("mem_write",   64'(bus.mem_write),          64'(e_mwr));
      chk("mem_address", 64'(bus.mem_address),        64'(e_addr));
      chk("mem_wdata",   64'(bus.mem_wdata),          64'(e_wdata));
      chk("mem_log2",    64'(bus.mem_log2_bytes),     64'(e_log2));
      chk("i_valid",     64'(bus.i_valid),            64'(e_iv));
      chk("i_data",      64'(bus.i_data),             64'(e_id));
      chk("d_valid",     64'(bus.d_valid),            64'(e_dv));
      chk("d_rdata",     64'(bus.d_rdata),            64'(e_dr));
      chk("i_haz",       64'(bus.i_mem_hazard),       64'(e_ihz));
      chk("d_issue_haz", 64'(bus.d_mem_issue_hazard), 64'(e_dihz));
      chk("d_recv_haz",  64'(bus.d_mem_recv_hazard),  64'(e_drhz));
      chk("valid_excl",  64'(bus.i_valid & bus.d_valid), 64'd0);
   endtask

   task automatic settle();
      #1;
      model_eval();
      check_all();
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      #1;
   endtask

   // Let an outstanding transaction finish after n_wait empty cycles.
   task automatic respond(input int n_wait, input logic [DW-1:0] rdata);
      for (int k = 0; k < n_wait; k++) begin
         settle();
         tick();
      end
      bus.mem_valid = 1'b1;
      bus.mem_rdata = rdata;
      settle();
      tick();
      bus.mem_valid = 1'b0;
   endtask

   logic [5:0] order;

   initial begin
      n_checks = 0;
      n_errors = 0;
      starve   = 0;
      bus.i_read = 1'b0; bus.i_address = '0; bus.flush = 1'b0;
      bus.d_read = 1'b0; bus.d_write = 1'b1; bus.d_address = 32'h10;
      bus.d_wdata = 64'h55; bus.d_log2_bytes = 3'd2;
      bus.mem_ready = 1'b1; bus.mem_valid = 1'b1; bus.mem_rdata = 64'h77;
      bus.i_read = 1'b1; bus.i_address = 32'h20;

      // Reset held with requests and a stray response present.
      settle();
      chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
      chk("rst_i_haz",     64'(bus.i_mem_hazard), 64'd1);
      tick();
      settle();
      @(negedge clock);
      bus.i_read = 1'b0; bus.d_write = 1'b0; bus.mem_valid = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Fetch with three-cycle latency.
      bus.i_read = 1'b1; bus.i_address = 32'h100; bus.mem_ready = 1'b1;
      settle();
      chk("t41_issue", 64'(bus.mem_read), 64'd1);
      chk("t41_addr",  64'(bus.mem_address), 64'h100);
      tick();
      bus.i_read = 1'b0;
      settle(); tick();
      settle(); tick();
      bus.mem_valid = 1'b1; bus.mem_rdata = 64'hDEAD;
      settle();
      chk("t41_ivalid", 64'(bus.i_valid), 64'd1);
      chk("t41_idata",  64'(bus.i_data),  64'hDEAD);
      tick();
      bus.mem_valid = 1'b0;
      bus.d_read = 1'b1; bus.d_address = 32'h80; bus.mem_ready = 1'b0;
      settle();
      chk("t41_idle", 64'(bus.mem_read), 64'd1);
      tick();
      bus.d_read = 1'b0; bus.mem_ready = 1'b1;

      // Simultaneous fetch and load: load first, fetch right after d_valid.
      bus.i_read = 1'b1; bus.i_address = 32'h400;
      bus.d_read = 1'b1; bus.d_address = 32'h2000; bus.d_log2_bytes = 3'd3;
      settle();
      chk("t42_data_first", 64'(bus.mem_address), 64'h2000);
      tick();
      bus.d_read = 1'b0;
      settle();
      chk("t42_recv_haz", 64'(bus.d_mem_recv_hazard), 64'd1);
      tick();
      bus.mem_valid = 1'b1; bus.mem_rdata = 64'h1111;
      settle();
      chk("t42_dvalid",     64'(bus.d_valid),  64'd1);
      chk("t42_no_turn",    64'(bus.mem_read), 64'd0);
      tick();
      bus.mem_valid = 1'b0;
      settle();
      chk("t42_fetch_next", 64'(bus.mem_address), 64'h400);
      tick();
      bus.i_read = 1'b0;
      respond(1, 64'h2222);

      // Starvation limit with both requests held.
      bus.i_read = 1'b1; bus.i_address = 32'h600;
      bus.d_read = 1'b1; bus.d_address = 32'h700;
      order = '0;
      for (int k = 0; k < 6; k++) begin
         settle();
         order = {order[4:0], (bus.mem_read && bus.mem_address == 32'h600)};
         tick();
         bus.mem_valid = 1'b1; bus.mem_rdata = 64'(k);
         settle();
         tick();
         bus.mem_valid = 1'b0;
      end
      chk("t43_order", 64'(order), 64'b000010);
      bus.i_read = 1'b0; bus.d_read = 1'b0;
      settle(); tick();

      // Flushed fetch drains; a store waits for the drain response.
      bus.i_read = 1'b1; bus.i_address = 32'h500;
      settle(); tick();
      bus.i_read = 1'b0;
      settle(); tick();
      bus.flush = 1'b1;
      settle();
      chk("t44_no_ivalid", 64'(bus.i_valid), 64'd0);
      tick();
      bus.flush = 1'b0;
      bus.d_write = 1'b1; bus.d_address = 32'h3100; bus.d_wdata = 64'hBEEF;
      settle();
      chk("t44_hold_store", 64'(bus.mem_write), 64'd0);
      tick();
      settle(); tick();
      bus.mem_valid = 1'b1; bus.mem_rdata = 64'h9999;
      settle();
      chk("t44_drain_ivalid", 64'(bus.i_valid), 64'd0);
      tick();
      bus.mem_valid = 1'b0;
      settle();
      chk("t44_store_issue", 64'(bus.mem_write), 64'd1);
      chk("t44_store_data",  64'(bus.mem_wdata), 64'hBEEF);
      tick();
      bus.d_write = 1'b0;
      respond(1, 64'h0);

      // Store stalled by mem_ready=0, then waiting for its acknowledge.
      bus.d_write = 1'b1; bus.d_address = 32'h3000; bus.d_wdata = 64'hCAFE;
      bus.d_log2_bytes = 3'd2; bus.mem_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("t45_issue_haz", 64'(bus.d_mem_issue_hazard), 64'd1);
         tick();
      end
      bus.mem_ready = 1'b1;
      settle();
      chk("t45_accept", 64'(bus.d_mem_issue_hazard), 64'd0);
      tick();
      bus.d_write = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t45_recv_haz", 64'(bus.d_mem_recv_hazard), 64'd1);
         tick();
      end
      bus.mem_valid = 1'b1; bus.mem_rdata = 64'h5;
      settle();
      chk("t45_ack", 64'(bus.d_valid), 64'd1);
      tick();
      bus.mem_valid = 1'b0;

      // Reset in WAIT_D; the late response must be ignored.
      bus.d_read = 1'b1; bus.d_address = 32'h40;
      settle(); tick();
      bus.d_read = 1'b0;
      settle(); tick();
      reset = 1'b0;
      settle();
      chk("t46_recv_haz_rst", 64'(bus.d_mem_recv_hazard), 64'd0);
      tick();
      reset = 1'b1;
      bus.mem_valid = 1'b1; bus.mem_rdata = 64'h4444;
      settle();
      chk("t46_no_dvalid", 64'(bus.d_valid), 64'd0);
      tick();
      bus.mem_valid = 1'b0;

      // Randomized traffic against the reference.
      for (int c = 0; c < 2500; c++) begin
         settle();
         tick();
         if (acc_i || !reset) bus.i_read = 1'b0;
         if (acc_d || !reset) begin
            bus.d_read = 1'b0; bus.d_write = 1'b0;
         end
         if (!bus.i_read && $urandom_range(0, 2) == 0) begin
            bus.i_read = 1'b1;
            bus.i_address = $urandom & 32'hFFFF_FFF8;
         end
         if (!(bus.d_read | bus.d_write) && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) bus.d_read = 1'b1;
            else bus.d_write = 1'b1;
            bus.d_address    = $urandom;
            bus.d_wdata      = {$urandom, $urandom};
            bus.d_log2_bytes = 3'($urandom_range(0, 7));
         end
         bus.flush     = ($urandom_range(0, 9) == 0);
         bus.mem_ready = ($urandom_range(0, 3) != 0);
         bus.mem_valid = (pend.size() != 0) ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 7) == 0);
         bus.mem_rdata = {$urandom, $urandom};
         reset = ($urandom_range(0, 199) != 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
